// File: rtl/sensor_event_fifo_if.sv
// Sensor-to-controller event handshake bundle for sensor_event_fifo.
// slave = the FIFO, master = the sensor/controller side driving it.
interface sensor_event_fifo_if #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_ready;
    logic              event_received;
    logic [ADDR_W-1:0] event_addr;
    logic              event_ack;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;
    logic              clear_stats;

    modport slave (
        input  in_valid, in_addr, event_ack, clear_stats,
        output in_ready, event_received, event_addr, count, overflow, drop_count
    );

    modport master (
        output in_valid, in_addr, event_ack, clear_stats,
        input  in_ready, event_received, event_addr, count, overflow, drop_count
    );
endinterface

// File: rtl/sensor_event_fifo.sv
// First-word-fall-through event queue between the sensor and the SNN controller,
// with sticky overflow flag and saturating drop counter for debug.
module sensor_event_fifo #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    sensor_event_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic [DROP_W-1:0] drops;

    logic not_full;
    logic not_empty;
    logic push;
    logic pop;
    logic drop;

    // Flags come from registered occupancy only, so no input reaches an output combinationally.
    assign not_full  = (cnt != CNT_W'(DEPTH));
    assign not_empty = (cnt != '0);
    assign push      = bus.in_valid & not_full;
    assign pop       = bus.event_ack & not_empty;
    assign drop      = bus.in_valid & ~not_full;

    assign bus.in_ready       = not_full;
    assign bus.event_received = not_empty;
    assign bus.event_addr     = not_empty ? mem[rd_ptr] : '0;
    assign bus.count          = cnt;
    assign bus.overflow       = ovf;
    assign bus.drop_count     = drops;

    // Storage is left uncleared on reset; the count gates every read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.in_addr;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf   <= 1'b0;
            drops <= '0;
        end else if (bus.clear_stats) begin
            ovf   <= 1'b0;
            drops <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drops != '1) drops <= drops + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_sensor_event_fifo.sv
// Directed + randomized bench for sensor_event_fifo against a queue-based model.
module tb_sensor_event_fifo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
    localparam int DROP_W = 8;
    localparam int DMAX   = (1 << DROP_W) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    sensor_event_fifo_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    sensor_event_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    int q[$];
    bit m_ovf = 0;
    int m_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".in_ready"},  32'(bus.in_ready),       32'(q.size() != DEPTH));
        chk({tag, ".received"},  32'(bus.event_received), 32'(q.size() != 0));
        chk({tag, ".addr"},      32'(bus.event_addr),     (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, ".count"},     32'(bus.count),          32'(q.size()));
        chk({tag, ".overflow"},  32'(bus.overflow),       32'(m_ovf));
        chk({tag, ".drops"},     32'(bus.drop_count),     32'(m_drops));
    endtask

    // Drive one cycle: inputs are applied 1 time unit after a rising edge, outputs
    // are checked against the model, then the model advances across the next edge.
    task automatic step(input bit v, input int a, input bit k, input bit c, input string tag);
        bit room, drop;
        bus.in_valid    = v;
        bus.in_addr     = ADDR_W'(a);
        bus.event_ack   = k;
        bus.clear_stats = c;
        chk_model(tag);
        room = (q.size() < DEPTH);
        drop = v && !room;
        if (k && q.size() > 0) void'(q.pop_front());
        if (v && room) q.push_back(a % (1 << ADDR_W));
        if (c) begin
            m_ovf = 0; m_drops = 0;
        end else if (drop) begin
            m_ovf = 1;
            if (m_drops < DMAX) m_drops++;
        end
        @(posedge clock);
        #1;
        bus.in_valid = 0; bus.event_ack = 0; bus.clear_stats = 0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (q.size() > 0 && guard < 4 * DEPTH) begin
            step(0, 0, 1, 0, tag);
            guard++;
        end
        chk({tag, ".drained"}, 32'(bus.event_received), 32'd0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_addr = '0; bus.event_ack = 0; bus.clear_stats = 0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b0;
        @(posedge clock); #1;

        // Reset state against literal values
        chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst.received", 32'(bus.event_received), 32'd0);
        chk("rst.addr", 32'(bus.event_addr), 32'd0);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.overflow", 32'(bus.overflow), 32'd0);
        chk("rst.drops", 32'(bus.drop_count), 32'd0);

        // Push 3,7,12 then single-cycle acks
        step(1, 3, 0, 0, "p3");
        chk("lat.received", 32'(bus.event_received), 32'd1);
        chk("lat.addr", 32'(bus.event_addr), 32'd3);
        step(1, 7, 0, 0, "p7");
        step(1, 12, 0, 0, "p12");
        chk("three.count", 32'(bus.count), 32'd3);
        step(0, 0, 1, 0, "a1");
        chk("ack1.addr", 32'(bus.event_addr), 32'd7);
        step(0, 0, 1, 0, "a2");
        chk("ack2.addr", 32'(bus.event_addr), 32'd12);
        step(0, 0, 1, 0, "a3");
        step(0, 0, 1, 0, "ack_empty");
        chk_model("idle");

        // Fill, overflow, drain, second fill to exercise pointer wrap
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, "fill");
        chk("full.in_ready", 32'(bus.in_ready), 32'd0);
        step(1, 9, 0, 0, "drop9");
        step(1, 10, 0, 0, "drop10");
        chk("full.overflow", 32'(bus.overflow), 32'd1);
        chk("full.drops", 32'(bus.drop_count), 32'd2);
        chk("full.head", 32'(bus.event_addr), 32'd0);
        drain("pop0_7");
        for (int i = 8; i < 16; i++) step(1, i, 0, 0, "fill2");
        chk("wrap.head", 32'(bus.event_addr), 32'd8);
        drain("pop8_15");

        // Full + push + ack: push dropped, pop proceeds
        for (int i = 0; i < 8; i++) step(1, 15 - i, 0, 0, "fill3");
        step(1, 1, 1, 0, "full_push_ack");
        chk("fpa.count", 32'(bus.count), 32'd7);
        chk("fpa.drops", 32'(bus.drop_count), 32'd3);
        drain("drain3");

        // Empty + push + ack: ack ignored
        step(1, 5, 1, 0, "empty_push_ack");
        chk("epa.count", 32'(bus.count), 32'd1);
        chk("epa.addr", 32'(bus.event_addr), 32'd5);
        drain("drain4");

        // Mid-level push + ack keeps count and order
        for (int i = 0; i < 4; i++) step(1, 2 * i, 0, 0, "fill4");
        step(1, 11, 1, 0, "mid_push_ack");
        chk("mpa.count", 32'(bus.count), 32'd4);
        drain("drain5");

        // Saturation then clear coinciding with a drop
        for (int i = 0; i < 8; i++) step(1, i, 0, 0, "fill5");
        for (int i = 0; i < 300; i++) step(1, 4, 0, 0, "sat");
        chk("sat.drops", 32'(bus.drop_count), 32'd255);
        step(1, 4, 0, 1, "clear_drop");
        chk("clr.overflow", 32'(bus.overflow), 32'd0);
        chk("clr.drops", 32'(bus.drop_count), 32'd0);
        drain("drain6");

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 99) < 60), int'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 3), "rand");
        drain("drain7");

        // Asynchronous reset mid-operation with 5 entries queued
        for (int i = 0; i < 5; i++) step(1, 9 + i, 0, 0, "fill6");
        step(1, 1, 0, 0, "drop_pre");   // no drop (count 5->6); keeps stats nonzero if any
        #2 reset = 1'b1;
        #1;
        chk("arst.received", 32'(bus.event_received), 32'd0);
        chk("arst.addr", 32'(bus.event_addr), 32'd0);
        chk("arst.count", 32'(bus.count), 32'd0);
        chk("arst.in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst.overflow", 32'(bus.overflow), 32'd0);
        q.delete(); m_ovf = 0; m_drops = 0;
        #3 reset = 1'b0;
        @(posedge clock); #1;
        step(1, 2, 0, 0, "post_rst_push");
        chk("prst.addr", 32'(bus.event_addr), 32'd2);
        chk("prst.count", 32'(bus.count), 32'd1);
        drain("drain8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
